patr_scan_ctrl: RTL and testbench

//  Sequencer for the Patr 4-bit pattern checker. On start, reads LEN bytes from data memory at

---
 rtl/patr_scan_ctrl_pkg.sv | 23 ++
 rtl/patr_scan_ctrl_patr.sv | 31 +++
 rtl/patr_scan_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_patr_scan_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/patr_scan_ctrl_pkg.sv
// Shared types for the Patr scan sequencer: FSM states and the bit-position
// mnemonic that selects which 4-bit window of a byte the checker compares.
package patr_scan_ctrl_pkg;

    typedef enum logic [2:0] {
        SC_IDLE  = 3'd0,
        SC_FETCH = 3'd1,
        SC_WAIT  = 3'd2,
        SC_CHECK = 3'd3,
        SC_DONE  = 3'd4
    } scan_state_t;

    // Window POSn covers byte bits [n+2:n-1]; 0 means no window selected.
    typedef enum logic [2:0] {
        POS_NONE = 3'd0,
        POS1     = 3'd1,
        POS2     = 3'd2,
        POS3     = 3'd3,
        POS4     = 3'd4,
        POS5     = 3'd5
    } BitPosition_mne;

endpackage

// File: rtl/patr_scan_ctrl_patr.sv
// Patr pattern checker: combinational compare of one 4-bit window of
// PatrSrcA against the low nibble of PatrSrcB.
module patr_scan_ctrl_patr
    import patr_scan_ctrl_pkg::*;
(
    input  logic [7:0]     PatrSrcA,
    input  logic [7:0]     PatrSrcB,
    input  BitPosition_mne position,
    output logic           PatrOut
);

    logic [3:0] window_s;
    logic       window_valid_s;

    // Select the window addressed by position and compare against the pattern.
    always_comb begin
        window_s       = 4'd0;
        window_valid_s = 1'b1;
        case (position)
            POS1:    window_s = PatrSrcA[3:0];
            POS2:    window_s = PatrSrcA[4:1];
            POS3:    window_s = PatrSrcA[5:2];
            POS4:    window_s = PatrSrcA[6:3];
            POS5:    window_s = PatrSrcA[7:4];
            default: window_valid_s = 1'b0;
        endcase
        // Upper pattern byte is architecturally zero; a non-zero value never matches.
        PatrOut = window_valid_s && (PatrSrcB[7:4] == 4'd0) && (window_s == PatrSrcB[3:0]);
    end

endmodule

// File: rtl/patr_scan_ctrl.sv
// Scan sequencer: walks LEN bytes of data memory from BASE, runs each byte
// through the Patr checker at all five positions and accumulates counts.
module patr_scan_ctrl
    import patr_scan_ctrl_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8,
    parameter int CNT_W  = 10
) (
    input  logic              CLK,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic [3:0]        pattern,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  match_count,
    output logic [CNT_W-1:0]  byte_hit_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    scan_state_t       state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [3:0]        pat_q, pat_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [2:0]        pos_q, pos_d;
    logic [7:0]        byte_q, byte_d;
    logic              hit_q, hit_d;
    logic [CNT_W-1:0]  match_q, match_d;
    logic [CNT_W-1:0]  bhit_q, bhit_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              patr_out_s;
    logic [LEN_W-1:0]  idx_next_s;

    patr_scan_ctrl_patr u_patr (
        .PatrSrcA (byte_q),
        .PatrSrcB ({4'd0, pat_q}),
        .position (BitPosition_mne'(pos_q)),
        .PatrOut  (patr_out_s)
    );

    assign idx_next_s = idx_q + LEN_W'(1);

    // Next-state logic; strobes are computed one cycle ahead so every output is a flop.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        pat_d   = pat_q;
        idx_d   = idx_q;
        pos_d   = pos_q;
        byte_d  = byte_q;
        hit_d   = hit_q;
        match_d = match_q;
        bhit_d  = bhit_q;
        rd_en_d = 1'b0;
        addr_d  = addr_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            SC_IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    len_d   = length;
                    pat_d   = pattern;
                    idx_d   = {LEN_W{1'b0}};
                    hit_d   = 1'b0;
                    match_d = {CNT_W{1'b0}};
                    bhit_d  = {CNT_W{1'b0}};
                    busy_d  = 1'b1;
                    if (length != {LEN_W{1'b0}}) begin
                        state_d = SC_FETCH;
                        rd_en_d = 1'b1;
                        addr_d  = base_addr;
                    end else begin
                        state_d = SC_DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = SC_IDLE;
                end
            end
            SC_FETCH: begin
                state_d = SC_WAIT;
            end
            SC_WAIT: begin
                byte_d  = mem_rd_data;
                pos_d   = 3'(POS1);
                state_d = SC_CHECK;
            end
            SC_CHECK: begin
                if (patr_out_s && (match_q != CNT_MAX)) begin
                    match_d = match_q + CNT_W'(1);
                end else begin
                    match_d = match_q;
                end
                if (pos_q == 3'(POS5)) begin
                    if ((hit_q || patr_out_s) && (bhit_q != CNT_MAX)) begin
                        bhit_d = bhit_q + CNT_W'(1);
                    end else begin
                        bhit_d = bhit_q;
                    end
                    hit_d = 1'b0;
                    idx_d = idx_next_s;
                    if (idx_q == (len_q - LEN_W'(1))) begin
                        state_d = SC_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = SC_FETCH;
                        rd_en_d = 1'b1;
                        addr_d  = base_q + ADDR_W'(idx_next_s);
                    end
                end else begin
                    hit_d = hit_q | patr_out_s;
                    pos_d = pos_q + 3'd1;
                end
            end
            SC_DONE: begin
                state_d = SC_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = SC_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset abandons any scan in progress.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SC_IDLE;
            base_q  <= {ADDR_W{1'b0}};
            len_q   <= {LEN_W{1'b0}};
            pat_q   <= 4'd0;
            idx_q   <= {LEN_W{1'b0}};
            pos_q   <= 3'd0;
            byte_q  <= 8'd0;
            hit_q   <= 1'b0;
            match_q <= {CNT_W{1'b0}};
            bhit_q  <= {CNT_W{1'b0}};
            rd_en_q <= 1'b0;
            addr_q  <= {ADDR_W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            pat_q   <= pat_d;
            idx_q   <= idx_d;
            pos_q   <= pos_d;
            byte_q  <= byte_d;
            hit_q   <= hit_d;
            match_q <= match_d;
            bhit_q  <= bhit_d;
            rd_en_q <= rd_en_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign mem_rd_en      = rd_en_q;
    assign mem_addr       = addr_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign match_count    = match_q;
    assign byte_hit_count = bhit_q;

endmodule

// File: tb/tb_patr_scan_ctrl.sv
// Scoreboard bench for patr_scan_ctrl: a default instance plus a CNT_W=2
// instance for saturation, sharing one behavioural data memory.
module tb_patr_scan_ctrl;

    typedef struct {
        logic [9:0] m;
        logic [9:0] h;
        int         cyc;
    } exp_t;

    logic       CLK = 1'b0;
    logic       reset_n;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;

    logic       start1, start2;
    logic [7:0] base1, base2, len1, len2;
    logic [3:0] pat1, pat2;
    logic       rd1, rd2, busy1, busy2, done1, done2;
    logic [7:0] addr1, addr2, rdata1, rdata2;
    logic [9:0] mc1, bh1;
    logic [1:0] mc2, bh2;

    logic [7:0] mem [256];
    exp_t       q1[$];
    exp_t       q2[$];
    logic [7:0] alog[$];
    exp_t       e1, e2;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Read data valid one cycle after the strobe; poison value otherwise.
    always @(posedge CLK) begin
        rdata1 <= rd1 ? mem[addr1] : 8'h5A;
        rdata2 <= rd2 ? mem[addr2] : 8'h5A;
    end

    patr_scan_ctrl dut1 (
        .CLK(CLK), .reset_n(reset_n), .start(start1), .base_addr(base1),
        .length(len1), .pattern(pat1), .mem_rd_en(rd1), .mem_addr(addr1),
        .mem_rd_data(rdata1), .busy(busy1), .done(done1),
        .match_count(mc1), .byte_hit_count(bh1)
    );

    patr_scan_ctrl #(.CNT_W(2)) dut2 (
        .CLK(CLK), .reset_n(reset_n), .start(start2), .base_addr(base2),
        .length(len2), .pattern(pat2), .mem_rd_en(rd2), .mem_addr(addr2),
        .mem_rd_data(rdata2), .busy(busy2), .done(done2),
        .match_count(mc2), .byte_hit_count(bh2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor for dut1: logs read addresses and scores every done pulse.
    always @(negedge CLK) begin
        if (rd1 === 1'b1) alog.push_back(addr1);
        if (done1 === 1'b1) begin
            if (q1.size() == 0) begin
                chk("dut1 done with no pending scan", q1.size(), 1);
            end else begin
                e1 = q1.pop_front();
                chk("dut1 match_count", mc1, e1.m);
                chk("dut1 byte_hit_count", bh1, e1.h);
                chk("dut1 done cycle", cyc, e1.cyc);
                chk("dut1 busy in done", busy1, 1);
            end
        end
    end

    // Monitor for dut2 (saturating counters).
    always @(negedge CLK) begin
        if (done2 === 1'b1) begin
            if (q2.size() == 0) begin
                chk("dut2 done with no pending scan", q2.size(), 1);
            end else begin
                e2 = q2.pop_front();
                chk("dut2 match_count", mc2, e2.m);
                chk("dut2 byte_hit_count", bh2, e2.h);
                chk("dut2 done cycle", cyc, e2.cyc);
            end
        end
    end

    task automatic issue1(input logic [7:0] b, input logic [7:0] l, input logic [3:0] p,
                          input logic [9:0] m, input logic [9:0] h);
        exp_t e;
        @(negedge CLK);
        alog.delete();
        base1 = b; len1 = l; pat1 = p; start1 = 1'b1;
        e.m = m; e.h = h; e.cyc = cyc + 1 + 7 * int'(l);
        q1.push_back(e);
        @(negedge CLK);
        start1 = 1'b0;
    endtask

    task automatic issue2(input logic [7:0] b, input logic [7:0] l, input logic [3:0] p,
                          input logic [9:0] m, input logic [9:0] h);
        exp_t e;
        @(negedge CLK);
        base2 = b; len2 = l; pat2 = p; start2 = 1'b1;
        e.m = m; e.h = h; e.cyc = cyc + 1 + 7 * int'(l);
        q2.push_back(e);
        @(negedge CLK);
        start2 = 1'b0;
    endtask

    task automatic wait_done(input int which, input int budget);
        int n = 0;
        while (((which == 1) ? done1 : done2) !== 1'b1 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        if (n >= budget) chk("done timeout", (which == 1) ? done1 : done2, 1);
    endtask

    task automatic chk_addr(input string name, input int i, input logic [7:0] exp);
        logic [31:0] act;
        act = (i < alog.size()) ? {24'd0, alog[i]} : 32'hFFFF_FFFF;
        chk(name, act, {24'd0, exp});
    endtask

    initial begin
        logic [7:0] wrap_addr [4];
        wrap_addr = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        // Reset held with start asserted: nothing moves.
        reset_n = 1'b0;
        start1 = 1'b1; base1 = 8'h33; len1 = 8'd5; pat1 = 4'hA;
        start2 = 1'b1; base2 = 8'h33; len2 = 8'd5; pat2 = 4'hA;
        repeat (3) begin
            @(negedge CLK);
            chk("reset dut1 outputs", {rd1, addr1, busy1, done1, mc1, bh1}, 0);
            chk("reset dut2 outputs", {rd2, addr2, busy2, done2, mc2, bh2}, 0);
        end
        start1 = 1'b0; start2 = 1'b0;
        reset_n = 1'b1;
        @(negedge CLK);

        // Single byte 0x0A vs 1010: POS1 only.
        mem[8'h10] = 8'h0A;
        issue1(8'h10, 8'd1, 4'b1010, 10'd1, 10'd1);
        wait_done(1, 40);
        chk("t2 read count", alog.size(), 1);
        chk_addr("t2 read addr", 0, 8'h10);
        @(negedge CLK);
        chk("t2 busy after done", busy1, 0);

        // AA (3 matches), 00 (0), 50 (POS4) -> 4 matches over 2 bytes.
        mem[8'h20] = 8'hAA; mem[8'h21] = 8'h00; mem[8'h22] = 8'h50;
        issue1(8'h20, 8'd3, 4'b1010, 10'd4, 10'd2);
        wait_done(1, 60);
        chk("t3 read count", alog.size(), 3);

        // Address wrap FE,FF,00,01; FF->5, 0F->1, 00->0, F0->1.
        mem[8'hFE] = 8'hFF; mem[8'hFF] = 8'h0F; mem[8'h00] = 8'h00; mem[8'h01] = 8'hF0;
        issue1(8'hFE, 8'd4, 4'b1111, 10'd7, 10'd3);
        wait_done(1, 60);
        chk("t4 read count", alog.size(), 4);
        for (int i = 0; i < 4; i++) chk_addr("t4 wrap addr", i, wrap_addr[i]);

        // Zero length: done next cycle, counts cleared, no reads.
        issue1(8'h55, 8'd0, 4'b1010, 10'd0, 10'd0);
        wait_done(1, 10);
        chk("t5 zero-length reads", alog.size(), 0);

        // len=2 with a stray start mid-scan and another in the DONE cycle.
        mem[8'h30] = 8'h0A; mem[8'h31] = 8'hAA;
        issue1(8'h30, 8'd2, 4'b1010, 10'd4, 10'd2);
        repeat (5) @(negedge CLK);
        base1 = 8'h00; len1 = 8'd5; pat1 = 4'h0; start1 = 1'b1;
        @(negedge CLK);
        start1 = 1'b0;
        wait_done(1, 40);
        base1 = 8'h10; len1 = 8'd1; pat1 = 4'hA; start1 = 1'b1;
        @(negedge CLK);
        start1 = 1'b0;
        chk("t5 busy after ignored start", busy1, 0);
        repeat (10) @(negedge CLK);
        chk("t5 read count", alog.size(), 2);
        chk_addr("t5 addr 0", 0, 8'h30);
        chk_addr("t5 addr 1", 1, 8'h31);
        chk("t5 busy stays low", busy1, 0);

        // Reset during CHECK of byte 2 (POS2).
        mem[8'h60] = 8'hAA; mem[8'h61] = 8'hAA; mem[8'h62] = 8'hAA;
        issue1(8'h60, 8'd3, 4'b1010, 10'd9, 10'd3);
        repeat (10) @(negedge CLK);
        chk("t6 progress before reset", mc1, 4);
        reset_n = 1'b0;
        #1;
        chk("t6 async reset outputs", {rd1, addr1, busy1, done1, mc1, bh1}, 0);
        q1.delete();
        @(negedge CLK);
        reset_n = 1'b1;
        repeat (20) @(negedge CLK);
        chk("t6 idle after reset", {busy1, mc1, bh1}, 0);
        issue1(8'h10, 8'd1, 4'b1010, 10'd1, 10'd1);
        wait_done(1, 40);

        // CNT_W=2: 3+1+1 matches saturate at 3; 3 hit bytes fit exactly.
        mem[8'h40] = 8'hAA; mem[8'h41] = 8'h0A; mem[8'h42] = 8'hA0;
        issue2(8'h40, 8'd3, 4'b1010, 10'd3, 10'd3);
        wait_done(2, 60);
        @(negedge CLK);
        chk("t6 dut2 pending empty", q2.size(), 0);
        chk("t6 dut1 pending empty", q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
